regfile_arbiter: RTL and testbench
==================================

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the register-file data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, giving the register-file address width (8 entries).
REQ-003 CLK  input  1  clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 req_a / req_b  input  1  request from requester A / B; held high until done_a / done_b.
REQ-006 we_a / we_b  input  1  1 = write, 0 = read; held stable while the request is high.
REQ-007 addr_a / addr_b  input  ADDR_WIDTH  target entry; held stable while the request is high.
REQ-008 wdata_a / wdata_b  input  DATA_WIDTH  write data; held stable while the request is high.
REQ-009 done_a / done_b  output  1  one-cycle completion pulse to A / B.
REQ-010 rdata_a / rdata_b  output  DATA_WIDTH  read result; valid only while the matching done is high and the operation is a read, else 0.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 rf_rd_en, rf_wr_en  output  1  register-file read and write enables, registered.
REQ-013 rf_addr  output  ADDR_WIDTH, rf_wdata  output  DATA_WIDTH  register-file address and write data, registered.
REQ-014 rf_rdata  input  DATA_WIDTH  register-file read data, which the register file registers one edge after rf_rd_en is sampled.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-016 In IDLE, if any request is high, the FSM SHALL select a winner, latch its we/addr/wdata onto the rf_* outputs and an owner flag, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 In ISSUE, the FSM SHALL assert exactly one of rf_rd_en (read) or rf_wr_en (write) for one cycle, and SHALL never assert both.
REQ-018 From ISSUE the FSM SHALL always move to RESP, with rf_rd_en and rf_wr_en deasserted in RESP.
REQ-019 In RESP, the FSM SHALL pulse done for the owner only; for a read, rdata of the owner SHALL equal rf_rdata in that cycle; the FSM SHALL then return to IDLE.
REQ-020 Latency SHALL be 3 cycles from the request being sampled in IDLE to the done pulse, and throughput SHALL be one operation per 3 cycles.
REQ-021 Requests arriving during ISSUE or RESP SHALL be ignored until the next IDLE.
REQ-022 If a requester keeps its request high after done, the block SHALL treat it as a new request in the next IDLE.
REQ-023 The non-owner's done and rdata SHALL stay 0 for the whole operation.
REQ-024 The arbitration policy on simultaneous requests SHALL be as defined under Configuration; a single request SHALL always be granted.

Reset
REQ-025 While RST is low, the block SHALL set state to IDLE, and all outputs (done_*, rdata_*, busy, rf_rd_en, rf_wr_en, rf_addr, rf_wdata) to 0.
REQ-026 While RST is low, the block SHALL set the owner flag and the round-robin pointer to favour A.
REQ-027 If reset is asserted mid-operation, the in-flight operation SHALL be abandoned with no done pulse; the requester SHALL reissue the operation.
REQ-028 After RST deasserts, the first arbitration SHALL occur on the first rising edge at which a request is high.

Configuration
REQ-029 The macro REGFILE_ARB_RR_EN SHALL select round-robin arbitration when defined: on simultaneous requests the requester not granted last SHALL win, and the pointer SHALL update on every grant.
REQ-030 When REGFILE_ARB_RR_EN is undefined, the block SHALL use fixed priority: A always wins on simultaneous requests, and no pointer register SHALL exist.

Verification
REQ-031 Write then read: A writes 16'hBEEF to addr 5, then A reads addr 5 -> rf_wr_en is high for 1 cycle with rf_addr=5 and rf_wdata=BEEF; the read returns rdata_a=BEEF with done_a at cycle 3.
REQ-032 Simultaneous requests with REGFILE_ARB_RR_EN defined and both requests held for 4 operations -> grant order is A, B, A, B, with done pulses 3 cycles apart.
REQ-033 Simultaneous requests with REGFILE_ARB_RR_EN undefined and both requests held -> A is granted every time, and B gets no done.
REQ-034 Reset mid-ISSUE: RST drops during ISSUE of a B write -> all outputs are 0 immediately, no done_b is issued, and busy=0.
REQ-035 Exclusivity over a random 1000-cycle run -> rf_rd_en and rf_wr_en are never both 1, done_a and done_b are never both 1, and every read returns the last written value, 0 after reset.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Request/response and register-file bus of the two-requester register-file arbiter.
// master: requesters plus register file; slave: the arbiter.
interface regfile_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) ();
  logic                  req_a;
  logic                  req_b;
  logic                  we_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic                  done_a;
  logic                  done_b;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  busy;
  logic                  rf_rd_en;
  logic                  rf_wr_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [DATA_WIDTH-1:0] rf_rdata;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, rf_rdata,
    input  done_a, done_b, rdata_a, rdata_b, busy, rf_rd_en, rf_wr_en, rf_addr, rf_wdata
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, rf_rdata,
    output done_a, done_b, rdata_a, rdata_b, busy, rf_rd_en, rf_wr_en, rf_addr, rf_wdata
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester register-file arbiter: IDLE -> ISSUE -> RESP, one operation per 3 cycles.
// Define REGFILE_ARB_RR_EN for round-robin arbitration; fixed priority (A first) otherwise.
module regfile_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input logic              CLK,
  input logic              RST,
  regfile_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_b_q;
  logic                  we_q;
  logic                  rf_rd_en_q;
  logic                  rf_wr_en_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;

  logic                  grant;
  logic                  grant_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign grant = bus.req_a | bus.req_b;

`ifdef REGFILE_ARB_RR_EN
  // Set when B should win the next tie, i.e. A was granted last.
  logic prefer_b_q;

  assign grant_b = bus.req_b & (~bus.req_a | prefer_b_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prefer_b_q <= 1'b0;
    end else if (state_q == StIdle && grant) begin
      prefer_b_q <= ~grant_b;
    end
  end
`else
  assign grant_b = bus.req_b & ~bus.req_a;
`endif

  assign sel_we    = grant_b ? bus.we_b    : bus.we_a;
  assign sel_addr  = grant_b ? bus.addr_b  : bus.addr_a;
  assign sel_wdata = grant_b ? bus.wdata_b : bus.wdata_a;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Enables are loaded on the grant edge so they are high during ISSUE only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner_b_q  <= 1'b0;
      we_q       <= 1'b0;
      rf_rd_en_q <= 1'b0;
      rf_wr_en_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else if (state_q == StIdle && grant) begin
      owner_b_q  <= grant_b;
      we_q       <= sel_we;
      rf_rd_en_q <= ~sel_we;
      rf_wr_en_q <= sel_we;
      rf_addr_q  <= sel_addr;
      rf_wdata_q <= sel_wdata;
    end else begin
      rf_rd_en_q <= 1'b0;
      rf_wr_en_q <= 1'b0;
    end
  end

  always_comb begin
    bus.done_a  = 1'b0;
    bus.done_b  = 1'b0;
    bus.rdata_a = '0;
    bus.rdata_b = '0;
    bus.busy    = (state_q != StIdle);
    if (state_q == StResp) begin
      if (owner_b_q) begin
        bus.done_b = 1'b1;
        if (!we_q) bus.rdata_b = bus.rf_rdata;
      end else begin
        bus.done_a = 1'b1;
        if (!we_q) bus.rdata_a = bus.rf_rdata;
      end
    end
  end

  assign bus.rf_rd_en = rf_rd_en_q;
  assign bus.rf_wr_en = rf_wr_en_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: checks grants, latency, read data and exclusivity.
module tb_regfile_arbiter;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef struct {
    bit          owner_b;
    bit          we;
    logic [15:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   fails = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] exp_mem[8];
  logic [15:0] rf_mem[8];
  bit          prefer_b;

  regfile_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  regfile_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Register-file model: read data registered one edge after rf_rd_en.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      bus.rf_rdata <= '0;
    end else begin
      if (bus.rf_wr_en) rf_mem[bus.rf_addr] <= bus.rf_wdata;
      if (bus.rf_rd_en) bus.rf_rdata <= rf_mem[bus.rf_addr];
    end
  end

  always @(negedge CLK) begin
    checks++;
    if (bus.rf_rd_en && bus.rf_wr_en) begin
      fails++;
      $display("FAIL rf_en_exclusive: rd_en=%b wr_en=%b, required not both", bus.rf_rd_en,
               bus.rf_wr_en);
    end
    checks++;
    if (bus.done_a && bus.done_b) begin
      fails++;
      $display("FAIL done_exclusive: done_a=%b done_b=%b, required not both", bus.done_a,
               bus.done_b);
    end
    checks++;
    if ((!bus.done_a && bus.rdata_a !== '0) || (!bus.done_b && bus.rdata_b !== '0)) begin
      fails++;
      $display("FAIL idle_rdata: rdata_a=%h rdata_b=%h without done, required 0", bus.rdata_a,
               bus.rdata_b);
    end
    if (bus.done_a || bus.done_b) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done_a=%b done_b=%b, required no done", bus.done_a,
                 bus.done_b);
      end else begin
        mon_e = sb.pop_front();
        if (bus.done_b !== mon_e.owner_b ||
            (mon_e.owner_b ? bus.rdata_b : bus.rdata_a) !== (mon_e.we ? 16'h0 : mon_e.data))
        begin
          fails++;
          $display("FAIL sb_done: owner_b=%b rdata=%h, required owner_b=%b rdata=%h",
                   bus.done_b, mon_e.owner_b ? bus.rdata_b : bus.rdata_a, mon_e.owner_b,
                   mon_e.we ? 16'h0 : mon_e.data);
        end
      end
    end
  end

  task automatic push_op(input bit b, input bit we, input logic [2:0] addr,
                         input logic [15:0] data);
    exp_t e;
    e.owner_b = b;
    e.we      = we;
    e.data    = we ? 16'h0 : exp_mem[addr];
    if (we) exp_mem[addr] = data;
    prefer_b = !b;
    sb.push_back(e);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    prefer_b = 1'b0;
  endtask

  // Drives one request or a simultaneous pair; each requester drops at its own done.
  task automatic issue(input bit ua, input bit ub, input bit wa, input logic [2:0] aa,
                       input logic [15:0] da, input bit wb, input logic [2:0] ab,
                       input logic [15:0] db);
    bit first_b;
    bit pa;
    bit pb;
    int n;
    int nd;
    first_b = (ua && ub) ? (RrEn && prefer_b) : ub;
    if (first_b) push_op(1'b1, wb, ab, db);
    else         push_op(1'b0, wa, aa, da);
    if (ua && ub) begin
      if (first_b) push_op(1'b0, wa, aa, da);
      else         push_op(1'b1, wb, ab, db);
    end
    @(negedge CLK);
    bus.req_a = ua; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
    bus.req_b = ub; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
    pa = ua; pb = ub; n = 0; nd = 0;
    while ((pa || pb) && n < 12) begin
      @(negedge CLK);
      n++;
      if ((pa && bus.done_a) || (pb && bus.done_b)) begin
        nd++;
        checks++;
        if (n !== 3 * nd - 1) begin
          fails++;
          $display("FAIL latency: done after %0d cycles, required %0d", n, 3 * nd - 1);
        end
        if (pa && bus.done_a) begin bus.req_a = 1'b0; pa = 1'b0; end
        if (pb && bus.done_b) begin bus.req_b = 1'b0; pb = 1'b0; end
      end
    end
    if (pa || pb) begin
      checks++;
      fails++;
      $display("FAIL issue_timeout: pending a=%b b=%b, required none", pa, pb);
      bus.req_a = 1'b0;
      bus.req_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 3'd7; bus.wdata_a = 16'hFFFF;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0;   bus.wdata_b = '0;
    clear_model();
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0 || bus.done_a !== 1'b0 || bus.done_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b done_a=%b done_b=%b, required 0 0 0", bus.busy,
               bus.done_a, bus.done_b);
    end
    checks++;
    if (bus.rf_rd_en !== 1'b0 || bus.rf_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_en: rd_en=%b wr_en=%b, required 0 0", bus.rf_rd_en, bus.rf_wr_en);
    end
    checks++;
    if (bus.rf_addr !== 3'd0 || bus.rf_wdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0 0", bus.rf_addr, bus.rf_wdata);
    end
    checks++;
    if (bus.rdata_a !== 16'h0 || bus.rdata_b !== 16'h0) begin
      fails++;
      $display("FAIL reset_rdata: a=%h b=%h, required 0 0", bus.rdata_a, bus.rdata_b);
    end
    bus.req_a = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_write_read();
    push_op(1'b0, 1'b1, 3'd5, 16'hBEEF);
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 3'd5; bus.wdata_a = 16'hBEEF;
    @(negedge CLK);
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_rd_en !== 1'b0 || bus.rf_addr !== 3'd5 ||
        bus.rf_wdata !== 16'hBEEF || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL wr_issue: wr=%b rd=%b addr=%h wdata=%h busy=%b, required 1 0 5 beef 1",
               bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wdata, bus.busy);
    end
    @(negedge CLK);
    checks++;
    if (bus.done_a !== 1'b1 || bus.rf_wr_en !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL wr_resp: done_a=%b wr=%b busy=%b, required 1 0 1", bus.done_a,
               bus.rf_wr_en, bus.busy);
    end
    bus.req_a = 1'b0;
    @(negedge CLK);
    push_op(1'b0, 1'b0, 3'd5, 16'h0);
    bus.req_a = 1'b1; bus.we_a = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.rf_rd_en !== 1'b1 || bus.rf_wr_en !== 1'b0 || bus.rf_addr !== 3'd5) begin
      fails++;
      $display("FAIL rd_issue: rd=%b wr=%b addr=%h, required 1 0 5", bus.rf_rd_en,
               bus.rf_wr_en, bus.rf_addr);
    end
    @(negedge CLK);
    checks++;
    if (bus.done_a !== 1'b1 || bus.rdata_a !== 16'hBEEF || bus.done_b !== 1'b0) begin
      fails++;
      $display("FAIL rd_resp: done_a=%b rdata_a=%h done_b=%b, required 1 beef 0", bus.done_a,
               bus.rdata_a, bus.done_b);
    end
    bus.req_a = 1'b0;
  endtask

  task automatic test_simultaneous();
    int n;
    int nd;
    int nb;
    for (int k = 0; k < 4; k++) begin
      if (RrEn && k % 2 == 1) push_op(1'b1, 1'b1, 3'd3, 16'h5678);
      else                    push_op(1'b0, 1'b1, 3'd2, 16'h1234);
    end
    @(negedge CLK);
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 3'd2; bus.wdata_a = 16'h1234;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 3'd3; bus.wdata_b = 16'h5678;
    n = 0; nd = 0; nb = 0;
    while (nd < 4 && n < 30) begin
      @(negedge CLK);
      n++;
      if (bus.done_a || bus.done_b) begin
        nd++;
        if (bus.done_b) nb++;
        checks++;
        if (n !== 3 * nd - 1) begin
          fails++;
          $display("FAIL sim_spacing: done %0d at cycle %0d, required %0d", nd, n, 3 * nd - 1);
        end
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    checks++;
    if (nd !== 4 || nb !== (RrEn ? 2 : 0)) begin
      fails++;
      $display("FAIL sim_grants: dones=%0d b_dones=%0d, required 4 %0d", nd, nb, RrEn ? 2 : 0);
    end
    issue(1'b1, 1'b0, 1'b0, 3'd3, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_reset_mid_issue();
    @(negedge CLK);
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 3'd6; bus.wdata_b = 16'hAAAA;
    @(negedge CLK);
    checks++;
    if (bus.rf_wr_en !== 1'b1 || bus.rf_addr !== 3'd6) begin
      fails++;
      $display("FAIL mid_issue: wr=%b addr=%h, required 1 6", bus.rf_wr_en, bus.rf_addr);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done_b !== 1'b0 || bus.rf_wr_en !== 1'b0 ||
        bus.rf_addr !== 3'd0 || bus.rf_wdata !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b done_b=%b wr=%b addr=%h wdata=%h, required all 0",
               bus.busy, bus.done_b, bus.rf_wr_en, bus.rf_addr, bus.rf_wdata);
    end
    bus.req_b = 1'b0;
    clear_model();
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (bus.done_b !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: done_b=%b busy=%b, required 0 0", bus.done_b, bus.busy);
      end
    end
    RST = 1'b1;
    issue(1'b0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd6, 16'h0);
    issue(1'b1, 1'b1, 1'b0, 3'd5, 16'h0, 1'b1, 3'd5, 16'hC0DE);
  endtask

  task automatic test_random();
    int unsigned k;
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(2);
      issue(k != 1, k != 0, 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
            1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_reset_mid_issue();
    test_random();
    repeat (2) @(negedge CLK);
    checks++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expected completions outstanding, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
